// File: rtl/seg7_scan_driver.sv
// Multiplexed N-digit 7-segment display driver.
// Holds a shadow copy of the digit codes and scans one anode at a time.
// Segment, anode and index outputs are registered. Leading-zero blanking,
// hex glyphs, blinking and whole-display blanking are applied before the
// output register.
module seg7_scan_driver #(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned BLINK_DIV      = 500000,
    parameter int unsigned LZB_KEEP       = 0,
    parameter int unsigned HEX_EN         = 0,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    parameter int unsigned AN_ACTIVE_LOW  = 0,
    localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits_in,
    input  logic                    load,
    input  logic                    blink_en,
    input  logic                    blank_all,
    output logic [6:0]              seg_out,
    output logic [NUM_DIGITS-1:0]   an_out,
    output logic [IdxW-1:0]         scan_idx
);

    localparam int unsigned ScanW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BlinkW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    // Pin levels of a dark display; XOR with these converts active-high to pin polarity.
    localparam logic [6:0]            SegOff = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [NUM_DIGITS-1:0] AnOff  = (AN_ACTIVE_LOW != 0) ? '1 : '0;

    logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic [ScanW-1:0]        scan_cnt_q, scan_cnt_d;
    logic [IdxW-1:0]         idx_q, idx_d;
    logic [BlinkW-1:0]       blink_cnt_q, blink_cnt_d;
    logic                    blink_on_q, blink_on_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [IdxW-1:0]         scan_idx_q;

    logic [NUM_DIGITS-1:0]   lz_blank;
    logic [3:0]              cur_code;
    logic                    cur_lz;
    logic [NUM_DIGITS-1:0]   cur_an;

    // Active-high segment pattern {a..g} for one digit code.
    function automatic logic [6:0] glyph(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0:    g = 7'b1111110;
            4'h1:    g = 7'b0110000;
            4'h2:    g = 7'b1101101;
            4'h3:    g = 7'b1111001;
            4'h4:    g = 7'b0110011;
            4'h5:    g = 7'b1011011;
            4'h6:    g = 7'b0011111;
            4'h7:    g = 7'b1110000;
            4'h8:    g = 7'b1111111;
            4'h9:    g = 7'b1110011;
            4'hA:    g = 7'b1110111;
            4'hB:    g = 7'b0011111;
            4'hC:    g = 7'b1001110;
            4'hD:    g = 7'b0111101;
            4'hE:    g = 7'b1001111;
            default: g = 7'b1000111;
        endcase
        if (HEX_EN == 0 && code > 4'h9) begin
            g = 7'b0000000;
        end
        return g;
    endfunction

    // Next-state for shadow register, scan counter/index and blink timer.
    always_comb begin
        shadow_d    = load ? digits_in : shadow_q;

        scan_cnt_d  = scan_cnt_q + ScanW'(1);
        idx_d       = idx_q;
        if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
            scan_cnt_d = '0;
            idx_d      = (idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : idx_q + IdxW'(1);
        end

        blink_cnt_d = blink_cnt_q + BlinkW'(1);
        blink_on_d  = blink_on_q;
        if (!blink_en) begin
            blink_cnt_d = '0;
            blink_on_d  = 1'b1;
        end else if (blink_cnt_q == BlinkW'(BLINK_DIV - 1)) begin
            blink_cnt_d = '0;
            blink_on_d  = ~blink_on_q;
        end
    end

    // Leading-zero mask: digit i blanks when it and every higher digit are zero.
    always_comb begin
        logic zero_above;
        zero_above = 1'b1;
        lz_blank   = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_above  = zero_above & (shadow_q[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_above && (i >= int'(LZB_KEEP));
        end
    end

    // Select the code, blank flag and anode of the digit being scanned.
    always_comb begin
        cur_code = 4'h0;
        cur_lz   = 1'b0;
        cur_an   = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (int'(idx_q) == i) begin
                cur_code  = shadow_q[4*i +: 4];
                cur_lz    = lz_blank[i];
                cur_an[i] = 1'b1;
            end
        end
    end

    // Output next-state: darkest condition wins, then convert to pin polarity.
    always_comb begin
        logic [6:0]            seg_lit;
        logic [NUM_DIGITS-1:0] an_lit;
        seg_lit = cur_lz ? 7'b0000000 : glyph(cur_code);
        an_lit  = cur_an;
        if (blank_all || !blink_on_q) begin
            seg_lit = 7'b0000000;
            an_lit  = '0;
        end
        seg_d = seg_lit ^ SegOff;
        an_d  = an_lit ^ AnOff;
    end

    // State and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q    <= '0;
            scan_cnt_q  <= '0;
            idx_q       <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b1;
            seg_q       <= SegOff;
            an_q        <= AnOff;
            scan_idx_q  <= '0;
        end else begin
            shadow_q    <= shadow_d;
            scan_cnt_q  <= scan_cnt_d;
            idx_q       <= idx_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            seg_q       <= seg_d;
            an_q        <= an_d;
            scan_idx_q  <= idx_q;
        end
    end

    assign seg_out  = seg_q;
    assign an_out   = an_q;
    assign scan_idx = scan_idx_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: two instances share stimulus.
// dut_a: active-high, LZB_KEEP=0, HEX_EN=0. dut_b: inverted pins, LZB_KEEP=1, HEX_EN=1.
module tb_seg7_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic [15:0] digits;
    logic       load;
    logic       blink_en;
    logic       blank_all;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic [1:0] sidx_a, sidx_b;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    logic [3:0] an_exp;

    always #5 clk = ~clk;

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(3), .BLINK_DIV(5), .LZB_KEEP(0),
        .HEX_EN(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
    ) dut_a (
        .clk(clk), .reset(reset), .digits_in(digits), .load(load),
        .blink_en(blink_en), .blank_all(blank_all),
        .seg_out(seg_a), .an_out(an_a), .scan_idx(sidx_a)
    );

    seg7_scan_driver #(
        .NUM_DIGITS(4), .SCAN_DIV(3), .BLINK_DIV(5), .LZB_KEEP(1),
        .HEX_EN(1), .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1)
    ) dut_b (
        .clk(clk), .reset(reset), .digits_in(digits), .load(load),
        .blink_en(blink_en), .blank_all(blank_all),
        .seg_out(seg_b), .an_out(an_b), .scan_idx(sidx_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    // Digit index shown on the outputs after edge n (n>=1) following reset release.
    function automatic int exp_idx();
        return ((edge_n - 1) / 3) % 4;
    endfunction

    function automatic logic [3:0] onehot(input int d);
        return 4'(1 << d);
    endfunction

    // Assert reset between edges, confirm outputs go dark without a clock, release.
    task automatic reset_phase();
        reset = 1'b1;
        #2;
        check("rst_seg_a", seg_a, 7'h00);
        check("rst_an_a", an_a, 4'h0);
        check("rst_idx_a", sidx_a, 2'd0);
        check("rst_seg_b", seg_b, 7'h7F);
        check("rst_an_b", an_b, 4'hF);
        check("rst_idx_b", sidx_b, 2'd0);
        @(posedge clk);
        #1;
        reset  = 1'b0;
        edge_n = 0;
    endtask

    logic [6:0] seg_a_t [4] = '{7'h5B, 7'h7E, 7'h30, 7'h00};
    logic [6:0] seg_b_t [4] = '{7'h24, 7'h01, 7'h4F, 7'h7F};

    initial begin
        reset     = 1'b1;
        digits    = 16'h0000;
        load      = 1'b0;
        blink_en  = 1'b0;
        blank_all = 1'b0;

        // Scan walk with digits 0105
        reset_phase();
        digits = 16'h0105;
        load   = 1'b1;
        tick();
        load = 1'b0;
        check("t2_pre_seg_a", seg_a, 7'h00);
        check("t2_pre_an_a", an_a, 4'b0001);
        tick();
        check("t2_lat_seg_a", seg_a, 7'h5B);
        check("t2_lat_seg_b", seg_b, 7'h24);
        tick();
        check("t2_dwell_an_a", an_a, 4'b0001);
        for (int k = 1; k <= 4; k++) begin
            int d;
            d = k % 4;
            while (edge_n < 3 * k + 1) tick();
            an_exp = ~onehot(d);
            check("t2_an_a", an_a, onehot(d));
            check("t2_seg_a", seg_a, seg_a_t[d]);
            check("t2_idx_a", sidx_a, d);
            check("t2_an_b", an_b, an_exp);
            check("t2_seg_b", seg_b, seg_b_t[d]);
        end
        while (edge_n < 19) tick();
        check("t1_midscan_idx", sidx_a, 2'd2);

        // Reset mid-scan, then all-zero display
        reset_phase();
        digits = 16'h0000;
        load   = 1'b1;
        tick();
        load = 1'b0;
        for (int d = 0; d < 4; d++) begin
            while (edge_n < 3 * d + 2) tick();
            an_exp = ~onehot(d);
            check("t3_seg_a", seg_a, 7'h00);
            check("t3_an_a", an_a, onehot(d));
            check("t3_seg_b", seg_b, (d == 0) ? 7'h01 : 7'h7F);
            check("t3_an_b", an_b, an_exp);
        end

        // Hex code C and load latency
        reset_phase();
        digits = 16'h000C;
        load   = 1'b1;
        tick();
        load = 1'b0;
        check("t4_e1_seg_b", seg_b, 7'h01);
        tick();
        check("t4_hex_seg_b", seg_b, 7'h31);
        check("t4_nohex_seg_a", seg_a, 7'h00);
        check("t4_nohex_an_a", an_a, 4'b0001);

        // Blink 5 on / 5 off, then release, then blank_all pulse
        reset_phase();
        digits   = 16'h0008;
        load     = 1'b1;
        blink_en = 1'b1;
        tick();
        load = 1'b0;
        for (int n = 1; n <= 17; n++) begin
            bit lit;
            if (n > 1) tick();
            lit = (((n - 1) / 5) % 2) == 0;
            check("t5_blink_an_a", an_a, lit ? onehot(exp_idx()) : 4'h0);
            if (!lit) check("t5_blink_seg_a", seg_a, 7'h00);
        end
        check("t5_dark_idx_a", sidx_a, exp_idx());
        blink_en = 1'b0;
        tick();
        check("t5_off_still_dark", an_a, 4'h0);
        tick();
        check("t5_restore_an_a", an_a, onehot(exp_idx()));
        blank_all = 1'b1;
        tick();
        check("t5_blank_an_a", an_a, 4'h0);
        check("t5_blank_seg_a", seg_a, 7'h00);
        check("t5_blank_an_b", an_b, 4'hF);
        check("t5_blank_seg_b", seg_b, 7'h7F);
        check("t5_blank_idx_a", sidx_a, exp_idx());
        tick();
        tick();
        check("t5_blank_idx_run", sidx_a, exp_idx());
        check("t5_blank_hold_an", an_a, 4'h0);
        blank_all = 1'b0;
        tick();
        check("t5_unblank_an_a", an_a, onehot(exp_idx()));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule
